// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, IF/ID write/flush, multi-cycle imem wait states.
// Optional perf counters (stall_cnt, flush_cnt) are built only when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        fetch_done,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Defaults are the boot/reset output values; each S_RUN rule overrides only what differs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b0;
    fetch_done  = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      state_nxt = S_BOOT;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
        S_RUN: begin
          fetch_done = (cnt == CNT_LAST);
          if (load_use) begin
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
          end else if (jump || branch_taken) begin
            pc_write   = 1'b1;
            pc_src     = jump ? 2'b10 : 2'b01;
            ifid_write = 1'b1;
            cnt_nxt    = '0;
          end else if (halt_req) begin
            ifid_write = 1'b1;
            state_nxt  = S_HALT;
            cnt_nxt    = '0;
          end else if (cnt != CNT_LAST) begin
            ifid_write = 1'b1;
            cnt_nxt    = cnt + CNT_W'(1);
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            cnt_nxt    = '0;
          end
        end
        S_HALT: begin
          halted     = 1'b1;
          ifid_write = 1'b1;
          if (resume) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_BOOT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_ev;
  logic redirect_ev;

  assign stall_ev    = (state == S_RUN) && !rst &&
                       (load_use || (!jump && !branch_taken && !halt_req && (cnt != CNT_LAST)));
  assign redirect_ev = (state == S_RUN) && !rst && !load_use && (jump || branch_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
      if (redirect_ev && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus;
// a cycle model pushes expected outputs, which are popped and compared on the falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] BR_TGT = 32'h0000_0100;
  localparam logic [31:0] JP_TGT = 32'h0000_0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, load_use = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0;

  logic        pc_write    [2];
  logic [1:0]  pc_src      [2];
  logic        ifid_write  [2];
  logic        ifid_flush  [2];
  logic        idex_bubble [2];
  logic        fetch_done  [2];
  logic        halted      [2];
  logic [15:0] stall_cnt   [2];
  logic [15:0] flush_cnt   [2];
  logic [7:0]  dut_o       [2];
  logic [31:0] dut_pc      [2];

  fetch_ctrl #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken), .jump(jump),
    .halt_req(halt_req), .resume(resume), .pc_write(pc_write[0]), .pc_src(pc_src[0]),
    .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]),
    .fetch_done(fetch_done[0]), .halted(halted[0]), .stall_cnt(stall_cnt[0]),
    .flush_cnt(flush_cnt[0])
  );

  fetch_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken), .jump(jump),
    .halt_req(halt_req), .resume(resume), .pc_write(pc_write[1]), .pc_src(pc_src[1]),
    .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]),
    .fetch_done(fetch_done[1]), .halted(halted[1]), .stall_cnt(stall_cnt[1]),
    .flush_cnt(flush_cnt[1])
  );

  assign dut_o[0] = {pc_write[0], pc_src[0], ifid_write[0], ifid_flush[0],
                     idex_bubble[0], fetch_done[0], halted[0]};
  assign dut_o[1] = {pc_write[1], pc_src[1], ifid_write[1], ifid_flush[1],
                     idex_bubble[1], fetch_done[1], halted[1]};

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] src);
    case (src)
      2'b00:   return pc + 32'd4;
      2'b01:   return BR_TGT;
      2'b10:   return JP_TGT;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // PC registers driven from each DUT's own pc_write/pc_src
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst)              dut_pc[k] <= '0;
      else if (pc_write[k]) dut_pc[k] <= next_pc(dut_pc[k], pc_src[k]);
    end
  end

  typedef struct {
    int          k;
    logic [7:0]  o;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // model state: 0 = boot, 1 = run, 2 = halt
  int          mst  [2] = '{0, 0};
  int          mcnt [2] = '{0, 0};
  int          lat  [2] = '{1, 3};
  logic [15:0] msc  [2] = '{16'd0, 16'd0};
  logic [15:0] mfc  [2] = '{16'd0, 16'd0};
  logic [31:0] mpc  [2] = '{32'd0, 32'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Output vector order: pc_write, pc_src[1:0], ifid_write, ifid_flush, idex_bubble, fetch_done, halted
  task automatic model(input int k, input logic r, lu, bt, j, hr, rs,
                       output logic [7:0] o, output int nst, output int ncnt,
                       output bit st_inc, output bit fl_inc);
    logic fd;
    o      = 8'b0_00_0_1_0_0_0;
    nst    = 1;
    ncnt   = 0;
    st_inc = 0;
    fl_inc = 0;
    fd     = (mcnt[k] == lat[k] - 1);
    if (r) begin
      nst = 0;
    end else if (mst[k] == 2) begin
      o   = 8'b0_00_1_1_0_0_1;
      nst = rs ? 1 : 2;
    end else if (mst[k] == 1) begin
      if (lu) begin
        o = {7'b0_00_0_0_1_0, 1'b0}; o[1] = fd;
        ncnt = mcnt[k]; st_inc = 1;
      end else if (j) begin
        o = 8'b1_10_1_1_0_0_0; o[1] = fd; fl_inc = 1;
      end else if (bt) begin
        o = 8'b1_01_1_1_0_0_0; o[1] = fd; fl_inc = 1;
      end else if (hr) begin
        o = 8'b0_00_1_1_0_0_0; o[1] = fd; nst = 2;
      end else if (!fd) begin
        o = 8'b0_00_1_1_0_0_0; ncnt = mcnt[k] + 1; st_inc = 1;
      end else begin
        o = 8'b1_00_1_0_0_1_0;
      end
    end
  endtask

  task automatic cyc(input logic r, lu, bt, j, hr, rs);
    logic [7:0] o   [2];
    int         nst [2];
    int         ncnt[2];
    bit         si  [2];
    bit         fi  [2];
    exp_t       e;
    @(posedge clk);
    #1;
    rst = r; load_use = lu; branch_taken = bt; jump = j; halt_req = hr; resume = rs;
    for (int k = 0; k < 2; k++) begin
      model(k, r, lu, bt, j, hr, rs, o[k], nst[k], ncnt[k], si[k], fi[k]);
      e.k = k;
      e.o = o[k];
`ifdef FETCH_PERF_CNT_EN
      e.sc = msc[k];
      e.fc = mfc[k];
`else
      e.sc = 16'd0;
      e.fc = 16'd0;
`endif
      e.pc = mpc[k];
      sb.push_back(e);
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("outs_lat%0d", lat[e.k]),  {24'd0, dut_o[e.k]},     {24'd0, e.o});
      check($sformatf("stall_lat%0d", lat[e.k]), {16'd0, stall_cnt[e.k]}, {16'd0, e.sc});
      check($sformatf("flush_lat%0d", lat[e.k]), {16'd0, flush_cnt[e.k]}, {16'd0, e.fc});
      check($sformatf("pc_lat%0d", lat[e.k]),    dut_pc[e.k],             e.pc);
    end
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        msc[k] = '0; mfc[k] = '0; mpc[k] = '0;
      end else begin
        if (si[k] && msc[k] != 16'hFFFF) msc[k] = msc[k] + 16'd1;
        if (fi[k] && mfc[k] != 16'hFFFF) mfc[k] = mfc[k] + 16'd1;
        if (o[k][7]) mpc[k] = next_pc(mpc[k], o[k][6:5]);
      end
      mst[k]  = nst[k];
      mcnt[k] = ncnt[k];
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Advance until the MEM_LAT=3 instance is running with the given access count
  task automatic align3(input int c);
    for (int i = 0; i < 8 && !(mst[1] == 1 && mcnt[1] == c); i++) idle(1);
  endtask

  initial begin
    // reset held 2 cycles, then boot and free-running fetch
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(10);
    // load-use for 2 cycles at issue
    align3(2);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);
    // jump and branch together mid-access
    align3(1);
    cyc(0, 0, 1, 1, 0, 0);
    idle(6);
    // load-use masks a branch; branch taken once load-use drops
    align3(0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    // halt, hazards ignored while halted, then resume
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, i % 3 == 0, i % 3 == 1, i % 3 == 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);
    // resume honoured with halt_req still high
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(4);
    // reset mid-access and in halt
    align3(1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4);
    // randomized mix
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
